// File: rtl/freq_cnt_pkg.sv
// Shared types and default constants for the gated frequency counter.
package freq_cnt_pkg;

   localparam int unsigned GATE_CYCLES_DEF = 50000000;
   localparam int unsigned CNT_W_DEF       = 32;

   // Measurement sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GATE = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/freq_gate_counter_rise_detect.sv
// rise_detect: one-cycle pulse on each rising edge of an already-synchronized level.
// The previous-level register tracks every cycle, so a level that is already
// high when a consumer starts looking never produces a pulse.
module rise_detect (
   input  logic clock,
   input  logic rst,
   input  logic sig_in,
   output logic rise_c
);

   logic prev_q;
   logic prev_d;

   // Previous level follows the input unconditionally
   always_comb begin
      prev_d = sig_in;
   end

   // Previous-level register, synchronous reset
   always_ff @(posedge clock) begin
      if (rst) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= prev_d;
      end
   end

   assign rise_c = sig_in & ~prev_q;

endmodule

// File: rtl/freq_gate_counter.sv
// freq_gate_counter: counts rising edges of sync_signal over a gate window of
// GATE_CYCLES clocks and publishes the count with a one-cycle valid strobe.
// Single-shot (start) or continuous back-to-back windows with one dead DONE cycle.
// Optional macro FREQ_CNT_OVF_EN: saturating edge count plus an overflow port
// that is loaded together with freq_count.
module freq_gate_counter
   import freq_cnt_pkg::*;
#(
   parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             sync_signal,
   input  logic             start,
   input  logic             continuous,
   output logic             busy,
   output logic [CNT_W-1:0] freq_count,
   output logic             freq_valid
`ifdef FREQ_CNT_OVF_EN
   ,
   output logic             overflow
`endif
);

   localparam int unsigned       GATE_W    = $clog2(GATE_CYCLES);
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

   state_t             state_q,      state_d;
   logic [GATE_W-1:0]  gate_cnt_q,   gate_cnt_d;
   logic [CNT_W-1:0]   edge_cnt_q,   edge_cnt_d;
   logic [CNT_W-1:0]   freq_count_q, freq_count_d;
   logic               freq_valid_q, freq_valid_d;
   logic               busy_q,       busy_d;

   logic               rise_c;
   logic               win_start_c;
   logic               win_close_c;
   logic [CNT_W-1:0]   edge_inc_c;

   rise_detect u_rise (
      .clock  (clock),
      .rst    (rst),
      .sig_in (sync_signal),
      .rise_c (rise_c)
   );

   // Window boundaries: a fresh window opens from IDLE on start or from DONE
   // when continuous; the window closes on its last gate cycle.
   always_comb begin
      win_start_c = ((state_q == IDLE) && start) ||
                    ((state_q == DONE) && continuous);
      win_close_c = (state_q == GATE) && (gate_cnt_q == GATE_LAST);
   end

`ifdef FREQ_CNT_OVF_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic sat_hit_c;
   logic sat_q, sat_d;
   logic ovf_q, ovf_d;

   // Edge count plus this cycle's rise, pinned at all-ones
   always_comb begin
      sat_hit_c  = 1'b0;
      edge_inc_c = edge_cnt_q + CNT_W'(rise_c);
      if (rise_c && (edge_cnt_q == CNT_MAX)) begin
         sat_hit_c  = 1'b1;
         edge_inc_c = CNT_MAX;
      end
   end

   // Sticky per-window saturation flag; published alongside freq_count
   always_comb begin
      sat_d = sat_q;
      ovf_d = ovf_q;
      if (win_start_c) begin
         sat_d = 1'b0;
      end else if (state_q == GATE) begin
         sat_d = sat_q | sat_hit_c;
      end
      if (win_close_c) begin
         ovf_d = sat_q | sat_hit_c;
      end
   end

   // Saturation and overflow registers
   always_ff @(posedge clock) begin
      if (rst) begin
         sat_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         sat_q <= sat_d;
         ovf_q <= ovf_d;
      end
   end

   assign overflow = ovf_q;
`else
   // Edge count plus this cycle's rise, wrapping modulo 2^CNT_W
   always_comb begin
      edge_inc_c = edge_cnt_q + CNT_W'(rise_c);
   end
`endif

   // Next-state and datapath update for the IDLE -> GATE -> DONE sequence
   always_comb begin
      state_d      = state_q;
      gate_cnt_d   = gate_cnt_q;
      edge_cnt_d   = edge_cnt_q;
      freq_count_d = freq_count_q;
      freq_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (win_start_c) begin
               state_d    = GATE;
               gate_cnt_d = '0;
               edge_cnt_d = '0;
            end
         end
         GATE: begin
            edge_cnt_d = edge_inc_c;
            if (win_close_c) begin
               freq_count_d = edge_inc_c;
               freq_valid_d = 1'b1;
               state_d      = DONE;
            end else begin
               gate_cnt_d = gate_cnt_q + GATE_W'(1);
            end
         end
         DONE: begin
            // Dead cycle: rises here are not counted
            if (win_start_c) begin
               state_d    = GATE;
               gate_cnt_d = '0;
               edge_cnt_d = '0;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State, counter and output registers, synchronous reset
   always_ff @(posedge clock) begin
      if (rst) begin
         state_q      <= IDLE;
         gate_cnt_q   <= '0;
         edge_cnt_q   <= '0;
         freq_count_q <= '0;
         freq_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         gate_cnt_q   <= gate_cnt_d;
         edge_cnt_q   <= edge_cnt_d;
         freq_count_q <= freq_count_d;
         freq_valid_q <= freq_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign busy       = busy_q;
   assign freq_count = freq_count_q;
   assign freq_valid = freq_valid_q;

endmodule

// File: tb/tb_freq_gate_counter.sv
// Bench for freq_gate_counter: two instances (CNT_W=8 and CNT_W=3, GATE_CYCLES=20)
// share one set of inputs; an integer-count model is compared every cycle and
// directed scenarios pin literal results.
module tb_freq_gate_counter;

   localparam int G = 20;

   logic       clock       = 1'b0;
   logic       rst         = 1'b1;
   logic       sync_signal = 1'b1;
   logic       start       = 1'b1;
   logic       continuous  = 1'b1;

   logic       busy_a, valid_a;
   logic [7:0] cnt_a;
   logic       busy_b, valid_b;
   logic [2:0] cnt_b;
`ifdef FREQ_CNT_OVF_EN
   logic       ovf_a, ovf_b;
`endif

   always #5 clock = ~clock;

   freq_gate_counter #(.GATE_CYCLES(G), .CNT_W(8)) dut_a (
      .clock       (clock),
      .rst         (rst),
      .sync_signal (sync_signal),
      .start       (start),
      .continuous  (continuous),
      .busy        (busy_a),
      .freq_count  (cnt_a),
      .freq_valid  (valid_a)
`ifdef FREQ_CNT_OVF_EN
      ,
      .overflow    (ovf_a)
`endif
   );

   freq_gate_counter #(.GATE_CYCLES(G), .CNT_W(3)) dut_b (
      .clock       (clock),
      .rst         (rst),
      .sync_signal (sync_signal),
      .start       (start),
      .continuous  (continuous),
      .busy        (busy_b),
      .freq_count  (cnt_b),
      .freq_valid  (valid_b)
`ifdef FREQ_CNT_OVF_EN
      ,
      .overflow    (ovf_b)
`endif
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int vcnt_a = 0;
   int last_v_a = 0;
   bit armed  = 1'b0;

   // pos: -1 idle, 0..G-1 position inside the gate window, G the dead cycle
   typedef struct {
      int     pos;
      longint rises;
      bit     prev;
      longint count;
      bit     valid;
      bit     busy;
      bit     ovf;
   } mdl_t;

   mdl_t ma, mb;

   function automatic mdl_t step(mdl_t m, bit r, bit s, bit st, bit c, int w);
      mdl_t   n    = m;
      longint mx   = (longint'(1) << w) - 1;
      bit     rise = s & ~m.prev;
      n.valid = 1'b0;
      if (r) begin
         n.pos = -1; n.rises = 0; n.prev = 1'b0; n.count = 0; n.ovf = 1'b0; n.busy = 1'b0;
         return n;
      end
      if (m.pos < 0) begin
         if (st) begin n.pos = 0; n.rises = 0; end
      end else if (m.pos < G) begin
         n.rises = m.rises + longint'(rise);
         if (m.pos == G - 1) begin
`ifdef FREQ_CNT_OVF_EN
            n.count = (n.rises > mx) ? mx : n.rises;
            n.ovf   = (n.rises > mx);
`else
            n.count = n.rises % (mx + 1);
`endif
            n.valid = 1'b1;
            n.pos   = G;
         end else begin
            n.pos = m.pos + 1;
         end
      end else begin
         if (c) begin n.pos = 0; n.rises = 0; end
         else n.pos = -1;
      end
      n.prev = s;
      n.busy = (n.pos >= 0);
      return n;
   endfunction

   task automatic check(string nm, longint act, longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Model advances on the same edge the DUTs sample their inputs
   always @(posedge clock) begin
      cyc <= cyc + 1;
      ma  <= step(ma, rst, sync_signal, start, continuous, 8);
      mb  <= step(mb, rst, sync_signal, start, continuous, 3);
      if (rst) armed <= 1'b1;
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clock) begin
      if (armed) begin
         check("a_valid", longint'(valid_a), longint'(ma.valid));
         check("a_busy",  longint'(busy_a),  longint'(ma.busy));
         check("a_count", longint'(cnt_a),   ma.count);
         check("b_valid", longint'(valid_b), longint'(mb.valid));
         check("b_busy",  longint'(busy_b),  longint'(mb.busy));
         check("b_count", longint'(cnt_b),   mb.count);
`ifdef FREQ_CNT_OVF_EN
         check("a_ovf",   longint'(ovf_a),   longint'(ma.ovf));
         check("b_ovf",   longint'(ovf_b),   longint'(mb.ovf));
`endif
         if (valid_a) begin
            vcnt_a   <= vcnt_a + 1;
            last_v_a <= cyc;
         end
      end
   end

   // Inputs change just after the falling edge, after that edge's comparisons
   task automatic drive(bit r, bit s, bit st, bit c);
      @(negedge clock);
      #1;
      rst         = r;
      sync_signal = s;
      start       = st;
      continuous  = c;
   endtask

   initial begin
      int v0;
      int t0;

      // Reset held for two edges while inputs toggle
      drive(1, 0, 1, 0);
      drive(0, 0, 0, 0);
      check("rst_busy_a",  longint'(busy_a),  0);
      check("rst_valid_a", longint'(valid_a), 0);
      check("rst_count_a", longint'(cnt_a),   0);
      check("rst_busy_b",  longint'(busy_b),  0);
      check("rst_count_b", longint'(cnt_b),   0);
      repeat (3) drive(0, 0, 0, 0);

      // Single shot, period-4 wave with first rise in gate cycle 1
      v0 = vcnt_a;
      drive(0, 0, 1, 0);
      t0 = cyc;
      for (int g = 0; g < 24; g++) drive(0, (g >= 1) && (((g - 1) % 4) < 2), 0, 0);
      check("t2_count",   longint'(cnt_a), 5);
      check("t2_pulses",  vcnt_a - v0, 1);
      check("t2_latency", last_v_a - t0, 21);
      check("t2_busy",    longint'(busy_a), 0);

      // Continuous with a level already high before start
      drive(0, 1, 0, 0);
      drive(0, 1, 0, 0);
      v0 = vcnt_a;
      drive(0, 1, 1, 1);
      t0 = cyc;
      for (int i = 0; i < 63; i++) drive(0, 1, 0, 1);
      check("t3_count",  longint'(cnt_a), 0);
      check("t3_pulses", vcnt_a - v0, 3);
      check("t3_last",   last_v_a - t0, 63);
      check("t3_busy",   longint'(busy_a), 1);
      for (int i = 0; i < 25; i++) drive(0, 0, 0, 0);
      check("t3_idle",   longint'(busy_a), 0);

      // Single rise in the last gate cycle
      drive(0, 0, 0, 0);
      drive(0, 0, 1, 0);
      for (int g = 0; g < 24; g++) drive(0, g == 19, 0, 0);
      check("t4_last_cycle", longint'(cnt_a), 1);

      // Rise only in the DONE cycle, then a continuous window with no new rise
      v0 = vcnt_a;
      drive(0, 0, 1, 1);
      for (int j = 0; j < 46; j++) drive(0, (j >= 20) && (j <= 40), 0, j <= 20);
      check("t4_done_rise", longint'(cnt_a), 0);
      check("t4_pulses",    vcnt_a - v0, 2);

      // start while busy is ignored
      v0 = vcnt_a;
      drive(0, 0, 1, 0);
      t0 = cyc;
      for (int g = 0; g < 24; g++)
         drive(0, (g >= 1) && (((g - 1) % 4) < 2), ((g >= 5) && (g <= 8)) || (g == 20), 0);
      check("t5_count",   longint'(cnt_a), 5);
      check("t5_pulses",  vcnt_a - v0, 1);
      check("t5_latency", last_v_a - t0, 21);

      // Reset at gate cycle 10 aborts the window
      v0 = vcnt_a;
      drive(0, 0, 1, 0);
      for (int g = 0; g < 30; g++) drive(g == 10, (g >= 1) && (((g - 1) % 4) < 2), 0, 0);
      check("t5_rst_pulses", vcnt_a - v0, 0);
      check("t5_rst_count",  longint'(cnt_a), 0);
      check("t5_rst_busy",   longint'(busy_a), 0);

      // Period-2 signal (10 rises), then a continuous window with 3 rises
      drive(0, 0, 0, 0);
      drive(0, 0, 1, 0);
      for (int j = 0; j < 46; j++) begin
         drive(0, (j < 20) ? ((j % 2) == 0) : ((j == 22) || (j == 24) || (j == 26)), 0, j <= 20);
         if (j == 22) begin
            check("t6_a_count", longint'(cnt_a), 10);
`ifdef FREQ_CNT_OVF_EN
            check("t6_b_sat",   longint'(cnt_b), 7);
            check("t6_b_ovf",   longint'(ovf_b), 1);
            check("t6_a_ovf",   longint'(ovf_a), 0);
`else
            check("t6_b_wrap",  longint'(cnt_b), 2);
`endif
         end
      end
      check("t6_b_next", longint'(cnt_b), 3);
      check("t6_a_next", longint'(cnt_a), 3);
`ifdef FREQ_CNT_OVF_EN
      check("t6_b_ovf_clr", longint'(ovf_b), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
